// File: rtl/mmio_uart_fifo_if.sv
// Bus, UART-core and interrupt signals of the memory-mapped UART front end.
interface mmio_uart_fifo_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic        bus_hit;
  logic [31:0] bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_re;
  logic        irq;

  // Core and UART-core side: issues loads/stores and reports transmitter/receiver state.
  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re, tx_busy, rx_data, rx_valid,
    input  bus_hit, bus_rdata, tx_data, tx_we, rx_re, irq
  );

  // Front-end side: decodes the register window and drives the UART cores.
  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re, tx_busy, rx_data, rx_valid,
    output bus_hit, bus_rdata, tx_data, tx_we, rx_re, irq
  );
endinterface

// File: rtl/mmio_uart_fifo.sv
// Memory-mapped UART front end: DATA/STATUS/CTRL registers, TX and RX byte
// FIFOs, a TX drain FSM paced by tx_busy, RX capture with overrun detection
// and a level interrupt.
module mmio_uart_fifo #(
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input logic              clk,
  input logic              rst,
  mmio_uart_fifo_if.slave  io
);

  localparam int unsigned TXAW = $clog2(TX_DEPTH);
  localparam int unsigned RXAW = $clog2(RX_DEPTH);
  localparam int unsigned TXCW = TXAW + 1;
  localparam int unsigned RXCW = RXAW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_WAIT  = 2'd2
  } tx_state_e;

  logic [31:0] off;
  logic        hit, wr_data, wr_stat, wr_ctrl, rd_data;

  logic [7:0]      tx_mem [TX_DEPTH];
  logic [TXAW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TXCW-1:0] tx_cnt_q, tx_cnt_d;
  logic            tx_empty, tx_full, tx_push, tx_idle;

  logic [7:0]      rx_mem [RX_DEPTH];
  logic [RXAW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RXCW-1:0] rx_cnt_q, rx_cnt_d;
  logic            rx_empty, rx_full, rx_push, rx_pop;

  tx_state_e   state_q, state_d;
  logic        tx_start;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_we_q, tx_we_d;
  logic        tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        irq_q, irq_d;
  logic [31:0] status, rdata;
  logic        unused_ok;

  // Address decode: the window spans DATA, STATUS and CTRL (12 bytes).
  assign off     = io.bus_addr - BASE_ADDR;
  assign hit     = (off < 32'd12);
  assign wr_data = hit && io.bus_we && (off[3:2] == 2'd0);
  assign wr_stat = hit && io.bus_we && (off[3:2] == 2'd1);
  assign wr_ctrl = hit && io.bus_we && (off[3:2] == 2'd2);
  assign rd_data = hit && io.bus_re && (off[3:2] == 2'd0);
  assign unused_ok = &{1'b0, off[31:4], off[1:0], io.bus_wdata[31:8]};

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TXCW'(TX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RXCW'(RX_DEPTH));
  assign tx_idle  = tx_empty && (state_q == S_IDLE);

  // A full RX FIFO still accepts a byte when software pops in the same cycle.
  assign tx_push = wr_data && !tx_full;
  assign rx_pop  = rd_data && !rx_empty;
  assign rx_push = io.rx_valid && (!rx_full || rx_pop);

  // TX drain FSM: launch a byte, hold off one guard cycle, then wait for the transmitter.
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_empty && !io.tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_GUARD;
        end
      end
      S_GUARD: state_d = S_WAIT;
      S_WAIT:  if (!io.tx_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer/count, sticky flag, control and interrupt next state.
  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_push)  tx_wr_d = tx_wr_q + TXAW'(1);
    if (tx_start) tx_rd_d = tx_rd_q + TXAW'(1);
    if (rx_push)  rx_wr_d = rx_wr_q + RXAW'(1);
    if (rx_pop)   rx_rd_d = rx_rd_q + RXAW'(1);
    case ({tx_push, tx_start})
      2'b10:   tx_cnt_d = tx_cnt_q + TXCW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - TXCW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RXCW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - RXCW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    // A flag raised by hardware wins over a software clear in the same cycle.
    tx_ovf_d  = (tx_ovf_q && !(wr_stat && io.bus_wdata[5])) || (wr_data && tx_full);
    rx_ovr_d  = (rx_ovr_q && !(wr_stat && io.bus_wdata[4])) || (io.rx_valid && rx_full && !rx_pop);
    ctrl_d    = wr_ctrl ? io.bus_wdata[1:0] : ctrl_q;
    irq_d     = (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_idle);
    tx_we_d   = tx_start;
    tx_data_d = tx_start ? tx_mem[tx_rd_q] : tx_data_q;
  end

  // Register read mux; counts and flags reflect state after the previous edge.
  always_comb begin
    status = {8'd0, 8'(tx_cnt_q), 8'(rx_cnt_q), 2'b00,
              tx_ovf_q, rx_ovr_q, rx_full, tx_idle, tx_full, !rx_empty};
    rdata  = '0;
    if (hit) begin
      case (off[3:2])
        2'd0:    rdata = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_q]};
        2'd1:    rdata = status;
        2'd2:    rdata = {30'd0, ctrl_q};
        default: rdata = '0;
      endcase
    end
  end

  // FIFO storage; reset flushes through the pointers, so the arrays need no reset.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= io.bus_wdata[7:0];
    if (rx_push) rx_mem[rx_wr_q] <= io.rx_data;
  end

  // Control and status state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      ctrl_q    <= '0;
      irq_q     <= 1'b0;
      tx_we_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovr_q  <= rx_ovr_d;
      ctrl_q    <= ctrl_d;
      irq_q     <= irq_d;
      tx_we_q   <= tx_we_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign io.bus_hit   = hit;
  assign io.bus_rdata = rdata;
  assign io.tx_data   = tx_data_q;
  assign io.tx_we     = tx_we_q;
  assign io.rx_re     = io.rx_valid;
  assign io.irq       = irq_q;

endmodule

// File: tb/tb_mmio_uart_fifo.sv
// Directed bench for mmio_uart_fifo with 4-entry FIFOs and a model
// transmitter that stays busy for 10 cycles after each start pulse.
module tb_mmio_uart_fifo;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;

  logic clk;
  logic rst;
  logic hold_busy;
  int   busy_cnt;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic [7:0] tx_bytes[$];
  int         tx_cyc[$];

  mmio_uart_fifo_if io();

  mmio_uart_fifo #(.TX_DEPTH(4), .RX_DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Model transmitter: records each start pulse and goes busy for 10 cycles.
  assign io.tx_busy = hold_busy || (busy_cnt != 0);
  always @(negedge clk) begin
    cyc++;
    if (io.tx_we === 1'b1) begin
      check("tx_we_while_busy", 32'(io.tx_busy), 32'd0);
      tx_bytes.push_back(io.tx_data);
      tx_cyc.push_back(cyc);
      busy_cnt = 10;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    io.bus_addr = a;
    io.bus_we   = 1'b0;
    io.bus_re   = 1'b0;
    #1;
    d = io.bus_rdata;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    io.bus_addr  = a;
    io.bus_wdata = d;
    io.bus_we    = 1'b1;
    tick();
    io.bus_we    = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    io.bus_addr = a;
    io.bus_re   = 1'b1;
    #1;
    d = io.bus_rdata;
    tick();
    io.bus_re   = 1'b0;
  endtask

  task automatic rx_in(input logic [7:0] b);
    io.rx_data  = b;
    io.rx_valid = 1'b1;
    #1;
    check("rx_re", 32'(io.rx_re), 32'd1);
    tick();
    io.rx_valid = 1'b0;
  endtask

  task automatic wait_tx_idle(input string tag);
    logic [31:0] st;
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      peek(A_STAT, st);
      if (st[2]) done = 1'b1;
      else tick();
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] st;
    logic [7:0]  prev;
    int          base;
    int          steps;
    bit          done;

    n_checks = 0; n_fail = 0; cyc = 0; busy_cnt = 0; hold_busy = 1'b0;
    io.bus_addr = '0; io.bus_wdata = '0; io.bus_we = 1'b0; io.bus_re = 1'b0;
    io.rx_data = '0; io.rx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // Reset values and window boundaries
    check("rst_tx_we", 32'(io.tx_we), 32'd0);
    check("rst_irq", 32'(io.irq), 32'd0);
    peek(A_STAT, rd);           check("rst_status", rd, 32'h0000_0004);
    peek(BASE + 32'hB, rd);     check("hit_last", 32'(io.bus_hit), 32'd1);
    peek(BASE + 32'hC, rd);     check("miss_above", 32'(io.bus_hit), 32'd0);
    check("miss_rdata", rd, 32'd0);
    peek(BASE - 32'h4, rd);     check("miss_below", 32'(io.bus_hit), 32'd0);
    rst = 1'b0;
    tick();

    // TX latency: write at edge N, pulse in the cycle after N+1
    bus_wr(A_DATA, 32'h5A);
    check("lat_n", 32'(io.tx_we), 32'd0);
    tick();
    check("lat_n1", 32'(io.tx_we), 32'd1);
    check("lat_data", 32'(io.tx_data), 32'h5A);
    tick();
    check("lat_n2", 32'(io.tx_we), 32'd0);
    wait_tx_idle("lat_idle");

    // TX pacing with 10-cycle busy per byte
    hold_busy = 1'b1;
    bus_wr(A_DATA, 32'h41);
    bus_wr(A_DATA, 32'h42);
    bus_wr(A_DATA, 32'h43);
    peek(A_STAT, st);
    check("pace_status3", st, 32'h0003_0000);
    base = tx_bytes.size();
    hold_busy = 1'b0;
    prev = 8'd3; steps = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      peek(A_STAT, st);
      if (st[23:16] != prev) begin
        check("pace_count_step", 32'(st[23:16]), 32'(prev - 8'd1));
        prev = st[23:16];
        steps++;
      end
      if (st[2]) done = 1'b1;
      else tick();
    end
    check("pace_idle", 32'(done), 32'd1);
    check("pace_steps", 32'(steps), 32'd3);
    check("pace_nbytes", 32'(tx_bytes.size() - base), 32'd3);
    if (tx_bytes.size() - base == 3) begin
      check("pace_b0", 32'(tx_bytes[base]),   32'h41);
      check("pace_b1", 32'(tx_bytes[base+1]), 32'h42);
      check("pace_b2", 32'(tx_bytes[base+2]), 32'h43);
      check("pace_gap1", 32'(tx_cyc[base+1] - tx_cyc[base]),   32'd12);
      check("pace_gap2", 32'(tx_cyc[base+2] - tx_cyc[base+1]), 32'd12);
    end

    // TX overflow: 6 writes into a 4-entry FIFO while the transmitter is busy
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) bus_wr(A_DATA, 32'h60 + 32'(i));
    peek(A_STAT, st);
    check("ovf_status", st, 32'h0004_0022);
    bus_wr(A_STAT, 32'h20);
    peek(A_STAT, st);
    check("ovf_cleared", st, 32'h0004_0002);
    base = tx_bytes.size();
    hold_busy = 1'b0;
    wait_tx_idle("ovf_idle");
    check("ovf_nbytes", 32'(tx_bytes.size() - base), 32'd4);
    if (tx_bytes.size() - base == 4)
      for (int i = 0; i < 4; i++) check("ovf_byte", 32'(tx_bytes[base+i]), 32'h60 + 32'(i));

    // RX overrun: 5 bytes into a 4-entry FIFO
    for (int i = 0; i < 5; i++) rx_in(8'h10 + 8'(i));
    peek(A_STAT, st);
    check("ovr_status", st, 32'h0000_041D);
    for (int i = 0; i < 4; i++) begin
      bus_rd(A_DATA, rd);
      check("ovr_read", rd, 32'h10 + 32'(i));
    end
    peek(A_STAT, st);
    check("ovr_drained", st, 32'h0000_0014);
    bus_rd(A_DATA, rd);
    check("ovr_empty_read", rd, 32'd0);
    bus_wr(A_STAT, 32'h10);
    peek(A_STAT, st);
    check("ovr_cleared", st, 32'h0000_0004);

    // Full RX FIFO: push and pop in the same cycle
    for (int i = 0; i < 4; i++) rx_in(8'h21 + 8'(i));
    peek(A_STAT, st);
    check("full_status", st, 32'h0000_040D);
    io.rx_data = 8'h25; io.rx_valid = 1'b1;
    bus_rd(A_DATA, rd);
    io.rx_valid = 1'b0;
    check("full_pp_read", rd, 32'h21);
    peek(A_STAT, st);
    check("full_pp_status", st, 32'h0000_040D);

    // Overrun set beats a same-cycle software clear
    io.rx_data = 8'h26; io.rx_valid = 1'b1;
    bus_wr(A_STAT, 32'h10);
    io.rx_valid = 1'b0;
    peek(A_STAT, st);
    check("set_beats_clear", st, 32'h0000_041D);
    for (int i = 0; i < 4; i++) begin
      bus_rd(A_DATA, rd);
      check("full_pp_drain", rd, 32'h22 + 32'(i));
    end
    bus_wr(A_STAT, 32'h10);
    peek(A_STAT, st);
    check("full_final", st, 32'h0000_0004);

    // Interrupt
    bus_wr(A_CTRL, 32'h1);
    tick();
    check("irq_rx_empty", 32'(io.irq), 32'd0);
    peek(A_CTRL, rd);
    check("ctrl_read", rd, 32'h1);
    rx_in(8'h55);
    check("irq_edge_n", 32'(io.irq), 32'd0);
    tick();
    check("irq_edge_n1", 32'(io.irq), 32'd1);
    bus_rd(A_DATA, rd);
    check("irq_read", rd, 32'h55);
    check("irq_pop_edge", 32'(io.irq), 32'd1);
    tick();
    check("irq_cleared", 32'(io.irq), 32'd0);
    bus_wr(A_CTRL, 32'h2);
    check("irq_tx_w", 32'(io.irq), 32'd0);
    tick();
    check("irq_tx_w1", 32'(io.irq), 32'd1);
    bus_wr(A_CTRL, 32'h0);
    tick();
    check("irq_off", 32'(io.irq), 32'd0);

    // Asynchronous reset in the middle of a transfer
    bus_wr(A_CTRL, 32'h1);
    rx_in(8'h77);
    tick();
    check("pre_rst_irq", 32'(io.irq), 32'd1);
    hold_busy = 1'b1;
    bus_wr(A_DATA, 32'h88);
    bus_wr(A_DATA, 32'h99);
    base = tx_bytes.size();
    hold_busy = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (tx_bytes.size() > base) done = 1'b1;
      else tick();
    end
    check("pre_rst_pulse", 32'(done), 32'd1);
    if (done) check("pre_rst_byte", 32'(tx_bytes[base]), 32'h88);
    tick();
    tick();
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_tx_we", 32'(io.tx_we), 32'd0);
    check("mid_rst_irq", 32'(io.irq), 32'd0);
    peek(A_STAT, st);
    check("mid_rst_status", st, 32'h0000_0004);
    tick();
    tick();
    rst = 1'b0;
    base = tx_bytes.size();
    repeat (40) tick();
    check("post_rst_no_tx", 32'(tx_bytes.size() - base), 32'd0);
    peek(A_STAT, st);
    check("post_rst_status", st, 32'h0000_0004);
    peek(A_CTRL, rd);
    check("post_rst_ctrl", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_fifo.md
# mmio_uart_fifo

Memory-mapped UART front end that sits between the core's MEM-stage data bus and the byte-level UART TX/RX cores, replacing the single-byte, no-buffer UART decode at 0x1000_0000/0x1000_0004. It adds parametrised TX and RX FIFOs, a TX drain state machine that respects `tx_busy`, an RX capture path with overrun detection, a control register and an interrupt output. The status register keeps bit0 = RX data available and bit1 = TX cannot accept, so existing polling firmware runs unchanged.

## Interface
- `TX_DEPTH`, 16: TX FIFO entries; power of 2, 2..128.
- `RX_DEPTH`, 16: RX FIFO entries; power of 2, 2..128.
- `BASE_ADDR`, 32'h1000_0000: byte address of the DATA register; word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `bus_addr` in 32: MEM-stage byte address.
- `bus_wdata` in 32: store data.
- `bus_we` in 1: store strobe, one cycle per access.
- `bus_re` in 1: load strobe, one cycle per access.
- `bus_hit` out 1: combinational; 1 when `bus_addr` is in BASE_ADDR+0x0..+0xB.
- `bus_rdata` out 32: combinational read data; 0 when `bus_hit`=0.
- `tx_data` out 8: byte to the UART transmitter.
- `tx_we` out 1: registered one-cycle start pulse to the transmitter.
- `tx_busy` in 1: transmitter busy.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: receiver holds a byte.
- `rx_re` out 1: combinational acknowledge; the receiver drops `rx_valid` on the next edge.
- `irq` out 1: registered level interrupt.

## Operation
- **Register map** (offsets from BASE_ADDR):
  - **+0x0 DATA**
    - Write: push `bus_wdata[7:0]` to the TX FIFO. If the TX FIFO is full, drop the byte and set `tx_ovf`.
    - Read: return `{24'b0, RX head}` and pop the head when `bus_re`=1. If the RX FIFO is empty, return 0 and do not pop.
  - **+0x4 STATUS** (read)
    - bit0 `rx_avail`
    - bit1 `tx_full`
    - bit2 `tx_idle` (TX FIFO empty and FSM in IDLE)
    - bit3 `rx_full`
    - bit4 `rx_ovr`
    - bit5 `tx_ovf`
    - [15:8] `rx_count`
    - [23:16] `tx_count`
    - remaining bits 0
  - **+0x4 STATUS** (write): writing 1 to bit4 or bit5 clears that sticky flag. Other bits are ignored.
  - **+0x8 CTRL** (read/write): bit0 `rx_ie`, bit1 `tx_ie`. Other bits read 0.
- **FIFOs**: circular buffers with read and write pointers that wrap modulo depth. Each count runs 0..DEPTH.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - Pop on an empty FIFO is ignored.
  - Push on a full FIFO is dropped.
- **RX capture**
  - `rx_re` = `rx_valid`.
  - If the RX FIFO is not full, `rx_data` is pushed.
  - If the RX FIFO is full and no pop occurs this cycle, the byte is discarded and `rx_ovr` is set.
  - If the FIFO is full and a pop occurs in the same cycle, the byte is pushed.
- **TX FSM**
  - IDLE: when the TX FIFO is non-empty and `tx_busy`=0, register `tx_data`=head, pulse `tx_we`, pop, and go to GUARD.
  - GUARD (1 cycle): ignore `tx_busy`, then go to WAIT.
  - WAIT: go to IDLE when `tx_busy`=0.
- **irq**: registered (`rx_ie` & `rx_avail`) | (`tx_ie` & `tx_idle`).
- **Simultaneous writes**: a CTRL or STATUS write in the same cycle as an internal event is resolved as follows.
  - Flag set by an event beats a software clear in the same cycle.
  - A CTRL write takes effect on `irq` one cycle later.

## Timing
- **Reset**
  - All outputs are 0 during and after reset.
  - FIFOs are empty, CTRL=0, flags are clear, FSM is in IDLE.
  - `rst` asserted mid-transfer aborts the transfer and flushes both FIFOs.
- **Load path**: `bus_rdata` is valid in the same cycle as `bus_addr`/`bus_re`. The pop takes effect at that cycle's rising edge.
- **TX latency**: a DATA write at edge N with an idle, empty TX path and `tx_busy`=0 makes `tx_we` high for exactly the cycle after edge N+1.
- **TX pacing**: the minimum spacing between successive `tx_we` pulses is 3 cycles, plus the time `tx_busy` stays high.
- **RX latency**
  - `rx_valid` sampled high at edge N makes the byte readable, and `rx_avail`=1, from edge N onward.
  - `irq` rises at edge N+1.
- **Status timing**: STATUS counts reflect state after the previous edge. No bypass from same-cycle pushes.

## Test plan
- **Reset**: assert `rst` asynchronously mid-cycle → `tx_we`=0, `irq`=0, STATUS reads 0x0000_0004 immediately.
- **TX pacing**: write 0x41, 0x42, 0x43 to DATA on back-to-back cycles with the model transmitter busy for 10 cycles per byte → `tx_we` pulses carry 0x41, 0x42, 0x43 in order, each pulse only after `tx_busy` falls. STATUS tx_count steps 3→2→1→0, then `tx_idle`=1.
- **TX overflow**: with `TX_DEPTH`=4 and `tx_busy` held high, issue 6 writes → tx_count=4 and `tx_ovf`=1. Writing 0x20 to STATUS clears `tx_ovf`. Release `tx_busy` → exactly 4 bytes are sent.
- **RX overrun**: with `RX_DEPTH`=4, push 5 bytes 0x10..0x14 and issue no reads → `rx_full`=1, `rx_ovr`=1. Reads return 0x10..0x13 followed by 0; `rx_avail` drops after the 4th read.
- **Full-FIFO same-cycle push and pop**: RX FIFO full and `rx_valid` asserted in the same cycle as a DATA read → the read returns the old head, the new byte is stored, the count stays at 4, and `rx_ovr` is not set.
- **Interrupt**: set CTRL=0x1 with the RX FIFO empty → `irq`=0. Inject 0x55 → `irq`=1 one cycle later. Read DATA → `irq` clears on the following edge. Set CTRL=0x2 with TX idle → `irq`=1.
